regfile_wr_arbiter: RTL
=======================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single general-purpose register file write port between two requesters.
//  - Requester 0: pipeline write-back stage (priority).
//  - Requester 1: multi-cycle result source, e.g. divider or load return.
//  Sits between those sources and the register file's we/waddr/wdata inputs.
//  Registers the granted write: one write per cycle, one-cycle latency, bounded starvation of requester 1.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive denied cycles of a valid req1 before req1 is forced a grant (1..15)
//  CNT_W         4  width of starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   reset, asynchronous, active-high
//  req0_valid in   1   write-back has a result
//  req0_addr  in   5   `RegAddrBus destination register
//  req0_data  in   32  `RegBus write data
//  req0_ready out  1   req0 accepted this cycle when valid&ready
//  req1_valid in   1   multi-cycle source has a result
//  req1_addr  in   5   `RegAddrBus destination register
//  req1_data  in   32  `RegBus write data
//  req1_ready out  1   req1 accepted this cycle when valid&ready
//  we         out  1   register file write enable (`WriteEnable)
//  waddr      out  5   register file write address
//  wdata      out  32  register file write data
//  busy1      out  1   FSM in FORCE1 (debug/perf visibility)
// BEHAVIOUR
//  Reset (async, immediate): we=0, waddr=0, wdata=`ZeroWord, state=NORMAL, cnt=0, busy1=0.
//  Handshake: transfer iff valid&ready at a rising edge.
//  - Requester holds valid/addr/data stable until accepted.
//  - ready is combinational from state, cnt and the valids; never from ready.
//  Output stage: a write accepted at edge N drives we=1, waddr, wdata during cycle N+1.
//  - Cycle with no acceptance: we=0 next cycle; waddr/wdata hold their last value.
//  - Sustained throughput is 1 write/cycle.
//  Address 0: request is accepted (ready=1, counts as a grant) but we stays 0. $0 is never written.
//  FSM states NORMAL, FORCE1:
//  - NORMAL: req0_ready=1; req1_ready=!req0_valid.
//    - cnt increments when req1_valid&req0_valid, i.e. req1 is denied.
//    - cnt clears when req1 is granted or req1_valid=0.
//    - Denied cycle with cnt==STARVE_LIMIT-1 -> FORCE1, cnt=0.
//  - FORCE1: req1_ready=1, req0_ready=0; always -> NORMAL next edge.
//    - If req1_valid=0 in FORCE1 (protocol violation), arbitrate as NORMAL this cycle, then -> NORMAL.
//  At most one acceptance per cycle, so same-address simultaneous requests never collide.
//  Per-requester order is preserved. Cross-requester order follows grant order.
//  Reset mid-burst: the registered write is dropped (we=0 at once). Un-accepted requests stay pending at their sources.
//  No read bypass here: the register file forwards from we/waddr/wdata itself.
// STRUCTURE
//  Widths and polarities (`RegAddrBus, `RegBus, `ZeroWord, `WriteEnable, `WriteDisable, `RegNumLog2) come from defines.v.
//  Add to defines.v:
//  - `ArbNormal / `ArbForce1 (1-bit state encodings)
//  - `StarveLimitDef
//  Single module, no sub-modules. Three parts:
//  - combinational grant/ready logic
//  - FSM + starvation counter
//  - output register
// TESTING
//  1. rst=1 between edges with we=1 -> we=0, waddr=0, wdata=0 immediately; after release req0_ready=1, req1_ready=1 (both valids low).
//  2. req0 valid addr=5 data=32'hDEADBEEF for one cycle at edge N -> we=1, waddr=5, wdata=DEADBEEF in cycle N+1; we=0 in N+2.
//  3. Both valid every cycle, STARVE_LIMIT=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; busy1 high on each req1 grant cycle.
//  4. req1 valid addr=0 data=32'h1234 -> req1_ready=1, accepted; we stays 0 the next cycle.
//  5. req1 alone, 8 back-to-back writes to addrs 1..8 -> we=1 for 8 consecutive cycles, addresses in order.
//  6. Enter FORCE1, then drop req1_valid with req0 valid -> req0 granted that cycle; state NORMAL next; cnt=0.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register file write-port arbiter.
// Encodings for register widths, write polarity and arbiter states.
package regfile_wr_arbiter_pkg;

    localparam int REG_NUM_LOG2 = 5;
    localparam int REG_W = 32;

    typedef logic [REG_NUM_LOG2-1:0] reg_addr_t;
    typedef logic [REG_W-1:0] reg_data_t;

    localparam reg_data_t ZERO_WORD = '0;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between write-back (priority)
// and a multi-cycle result source, with bounded starvation of the latter.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      req0_valid,
    input  reg_addr_t req0_addr,
    input  reg_data_t req0_data,
    output logic      req0_ready,
    input  logic      req1_valid,
    input  reg_addr_t req1_addr,
    input  reg_data_t req1_data,
    output logic      req1_ready,
    output logic      we,
    output reg_addr_t waddr,
    output reg_data_t wdata,
    output logic      busy1
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             force_act;
    logic             g0, g1;

    // FORCE1 only overrides priority while req1 actually has a result
    always_comb begin
        force_act  = (state == ARB_FORCE1) && req1_valid;
        req0_ready = !force_act;
        req1_ready = force_act || !req0_valid;
        g0         = req0_valid && req0_ready;
        g1         = req1_valid && req1_ready;
    end

    always_comb begin
        state_n = ARB_NORMAL;
        cnt_n   = '0;
        if (!force_act && req0_valid && req1_valid) begin
            if (cnt == LIMIT_M1) begin
                state_n = ARB_FORCE1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_NORMAL;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Writes to $0 are accepted but never reach the register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= WRITE_DISABLE;
            waddr <= '0;
            wdata <= ZERO_WORD;
        end else begin
            unique case (1'b1)
                g1: begin
                    we    <= (req1_addr != '0);
                    waddr <= req1_addr;
                    wdata <= req1_data;
                end
                g0: begin
                    we    <= (req0_addr != '0);
                    waddr <= req0_addr;
                    wdata <= req0_data;
                end
                default: we <= WRITE_DISABLE;
            endcase
        end
    end

    assign busy1 = (state == ARB_FORCE1);

endmodule
